// File: rtl/relay_sequencer_if.sv
// Signal bundle between the tap-relay register (master) and the relay sequencer (slave).
interface relay_sequencer_if #(
   parameter int WIDTH = 8
);
   // req is a level held by the master and may change at any time; there is no
   // valid/ready handshake. ready is a status level, high once rel_on == req is settled.
   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] rel_on;
   logic             ready;
   logic             busy;
   logic             all_off_n;

   modport master (output req, input rel_on, ready, busy, all_off_n);
   modport slave  (input req, output rel_on, ready, busy, all_off_n);
endinterface

// File: rtl/relay_sequencer.sv
// Applies a requested relay pattern break-before-make: drop relays, wait, then
// energise one relay per stagger gap, settle, and flag ready.
module relay_sequencer #(
   parameter int WIDTH          = 8,
   parameter int BREAK_CYCLES   = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int SETTLE_CYCLES  = 32,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   relay_sequencer_if.slave  bus,
   output logic [2:0]        state_dbg_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BREAK   = 3'd1,
      S_MAKE    = 3'd2,
      S_STAGGER = 3'd3,
      S_SETTLE  = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] REL_ONE = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [WIDTH-1:0] rel_q, rel_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             all_off_n_q, all_off_n_d;
   logic [WIDTH-1:0] off_mask, pending, lowest;

   always_comb begin
      s1_d        = bus.req;
      s2_d        = s1_q;
      s3_d        = s2_q;
      state_d     = state_q;
      rel_d       = rel_q;
      target_d    = target_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      off_mask    = rel_q & ~s2_q;
      pending     = target_q & ~rel_q;
      // Two's-complement trick isolates the lowest set pending bit.
      lowest      = pending & (~pending + REL_ONE);
      case (state_q)
         S_IDLE: begin
            if (s2_q == s3_q && s2_q != rel_q) begin
               target_d = s2_q;
               ready_d  = 1'b0;
               if (|off_mask) begin
                  rel_d   = rel_q & s2_q;
                  cnt_d   = CNT_W'(BREAK_CYCLES - 1);
                  state_d = S_BREAK;
               end else begin
                  state_d = S_MAKE;
               end
            end
         end
         S_BREAK, S_STAGGER: begin
            if (cnt_q == '0) state_d = S_MAKE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_MAKE: begin
            if (|pending) begin
               rel_d   = rel_q | lowest;
               cnt_d   = CNT_W'(STAGGER_CYCLES - 1);
               state_d = S_STAGGER;
            end else begin
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      all_off_n_d = ~|rel_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         rel_q       <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         all_off_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         rel_q       <= rel_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         all_off_n_q <= all_off_n_d;
      end
   end

   assign bus.rel_on    = rel_q;
   assign bus.ready     = ready_q;
   assign bus.busy      = ~ready_q;
   assign bus.all_off_n = all_off_n_q;
   assign state_dbg_o   = state_q;

endmodule
